// File: rtl/program_mem_if.sv
// Fetch-side bus between the RV32E fetch stage (master) and program_mem (slave):
// a valid/ready request channel carrying a byte address and a valid/ready response channel.
interface program_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/program_mem.sv
// Synchronous instruction memory with one-cycle registered fetch latency and fault flags.
// PROG_MEM_LOADER_EN: when defined the array is a loader-writable RAM, otherwise a built-in ROM.
module program_mem #(
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       NOP_WORD  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  program_mem_if.slave      bus,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a request transfers on an edge where req_valid && req_ready, a response
  // transfers where rsp_valid && rsp_ready; an untaken response is held stable.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> 2;
    return (a >= BASE_ADDR) && (off < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> 2;
    return IDX_W'(off);
  endfunction

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q,  rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [1:0]       rsp_fault_q, rsp_fault_d;

  logic [1:0]       req_fault;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic             req_ready;
  logic             accept;

`ifdef PROG_MEM_LOADER_EN
  logic [31:0] mem_array [DEPTH];

  // No reset on the array; a write and a fetch on the same edge read the old word.
  always_ff @(posedge clk) begin
    if (ld_en && in_range(ld_addr)) mem_array[word_idx(ld_addr)] <= ld_data;
  end

  assign rd_word = mem_array[rd_idx];
`else
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // Self-check program: store/load round trip, arithmetic, a counted loop, then spin.
  function automatic logic [31:0] rom_word(input logic [IDX_W-1:0] i);
    case (32'(i))
      0:       return enc_u(20'h00001, 5'd1, 7'h37);
      1:       return enc_i(12'd5, 5'd0, 3'b000, 5'd2, 7'h13);
      2:       return enc_s(12'd0, 5'd2, 5'd1, 3'b010);
      3:       return enc_i(12'd0, 5'd1, 3'b010, 5'd3, 7'h03);
      4:       return enc_i(12'h010, 5'd3, 3'b110, 5'd4, 7'h13);
      5:       return enc_r(7'h20, 5'd2, 5'd4, 3'b000, 5'd5);
      6:       return enc_b(12'd4, 5'd2, 5'd5, 3'b101);
      7:       return enc_i(12'd1, 5'd0, 3'b000, 5'd6, 7'h13);
      8:       return enc_i(12'd0, 5'd0, 3'b000, 5'd7, 7'h13);
      9:       return enc_i(12'd1, 5'd7, 3'b000, 5'd7, 7'h13);
      10:      return enc_b(12'hffe, 5'd2, 5'd7, 3'b100);
      11:      return enc_j(20'd0, 5'd0);
      default: return NOP_WORD;
    endcase
  endfunction

  assign rd_word = rom_word(rd_idx);

  logic unused_ld;
  assign unused_ld = ^{ld_en, ld_addr, ld_data};
`endif

  assign req_fault = {~in_range(bus.req_addr), |bus.req_addr[1:0]};
  assign rd_idx    = req_fault[1] ? '0 : word_idx(bus.req_addr);
  // A redirect always drains the output register, so the master is never stalled by flush.
  assign req_ready = !rsp_valid_q || bus.rsp_ready || flush;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_fault_d = rsp_fault_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = (|req_fault) ? NOP_WORD : rd_word;
      rsp_addr_d  = bus.req_addr;
      rsp_fault_d = req_fault;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= NOP_WORD;
      rsp_addr_q  <= '0;
      rsp_fault_q <= 2'b00;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_program_mem.sv
// Bench for program_mem: directed scenarios plus a randomized run against a transaction model.
module tb_program_mem;
  localparam int          DEPTH = 24;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  program_mem_if #(.ADDR_W(32)) bus ();

  program_mem #(
    .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_mem [DEPTH];
  logic [65:0] exp_q[$];
  logic [66:0] rsp_vec;

  assign rsp_vec = {bus.rsp_valid, bus.rsp_fault, bus.rsp_addr, bus.rsp_data};

  function automatic logic [31:0] rom_ref(input int i);
    case (i)
      0: return 32'h0000_10b7;  1: return 32'h0050_0113;  2: return 32'h0020_a023;
      3: return 32'h0000_a183;  4: return 32'h0101_e213;  5: return 32'h4022_02b3;
      6: return 32'h0022_d463;  7: return 32'h0010_0313;  8: return 32'h0000_0393;
      9: return 32'h0013_8393; 10: return 32'hfe23_cee3; 11: return 32'h0000_006f;
      default: return NOP;
    endcase
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
  endfunction

  function automatic logic [65:0] model_fetch(input logic [31:0] a);
    logic [1:0] f;
    f[0] = (a % 4) != 0;
    f[1] = !addr_ok(a);
    return {f, a, (f != 2'b00) ? NOP : exp_mem[(a - BASE) / 4]};
  endfunction

  task automatic drive_idle();
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b1;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_vec !== {1'b0, 2'b00, 32'h0, NOP}) begin
      errors++; $display("FAIL reset_outputs got %h want %h", rsp_vec, {1'b0, 2'b00, 32'h0, NOP});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef PROG_MEM_LOADER_EN
      exp_mem[i] = $urandom;
      ld_en = 1'b1; ld_addr = BASE + 32'(4 * i); ld_data = exp_mem[i];
      tick();
`else
      exp_mem[i] = rom_ref(i);
`endif
    end
    ld_en = 1'b0;
  endtask

  task automatic test_load_fetch();
`ifdef PROG_MEM_LOADER_EN
    ld_en = 1'b1; ld_addr = BASE + 32'h8; ld_data = 32'haabb_ccdd;
    exp_mem[2] = 32'haabb_ccdd;
    tick();
    ld_en = 1'b0;
`endif
    bus.req_valid = 1'b1; bus.req_addr = BASE + 32'h8; bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL load_fetch_ready got %b want 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (rsp_vec !== {1'b1, 2'b00, BASE + 32'h8, exp_mem[2]}) begin
      errors++; $display("FAIL load_fetch_rsp got %h want %h", rsp_vec, {1'b1, 2'b00, BASE + 32'h8, exp_mem[2]});
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL load_fetch_drain got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      a = BASE + 32'(4 * k);
      bus.req_valid = 1'b1; bus.req_addr = a;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready word %0d got %b want 1", k, bus.req_ready);
      end
      tick();
      checks++;
      if (rsp_vec !== {1'b1, 2'b00, a, exp_mem[k]}) begin
        errors++; $display("FAIL b2b_rsp word %0d got %h want %h", k, rsp_vec, {1'b1, 2'b00, a, exp_mem[k]});
      end
    end
    bus.req_valid = 1'b0;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = BASE + 32'h4;
    tick();
    bus.req_addr = BASE + 32'h8;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready cycle %0d got %b want 0", c, bus.req_ready);
      end
      tick();
      checks++;
      if (rsp_vec !== {1'b1, 2'b00, BASE + 32'h4, exp_mem[1]}) begin
        errors++; $display("FAIL bp_hold cycle %0d got %h want %h", c, rsp_vec, {1'b1, 2'b00, BASE + 32'h4, exp_mem[1]});
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b want 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (rsp_vec !== {1'b1, 2'b00, BASE + 32'h8, exp_mem[2]}) begin
      errors++; $display("FAIL bp_next_rsp got %h want %h", rsp_vec, {1'b1, 2'b00, BASE + 32'h8, exp_mem[2]});
    end
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] addrs [6];
    logic [1:0]  faults [6];
    logic [31:0] datas [6];
    addrs  = '{BASE + 32'h6, BASE + 32'(4 * DEPTH), BASE + 32'(4 * DEPTH + 2),
               32'h0, BASE - 32'h4, BASE + 32'(4 * (DEPTH - 1))};
    faults = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00};
    datas  = '{NOP, NOP, NOP, NOP, NOP, exp_mem[DEPTH-1]};
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = 1'b1; bus.req_addr = addrs[k];
      tick();
      checks++;
      if (rsp_vec !== {1'b1, faults[k], addrs[k], datas[k]}) begin
        errors++; $display("FAIL fault_rsp case %0d got %h want %h", k, rsp_vec, {1'b1, faults[k], addrs[k], datas[k]});
      end
    end
    bus.req_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = BASE;
    tick();
    flush = 1'b1; bus.req_addr = BASE + 32'h10;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready got %b want 1", bus.req_ready);
    end
    tick();
    flush = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL flush_drop cycle %0d got %b want 0", c, bus.rsp_valid);
      end
      tick();
    end
    bus.req_valid = 1'b1; bus.req_addr = BASE + 32'hc;
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (rsp_vec !== {1'b1, 2'b00, BASE + 32'hc, exp_mem[3]}) begin
      errors++; $display("FAIL flush_redirect got %h want %h", rsp_vec, {1'b1, 2'b00, BASE + 32'hc, exp_mem[3]});
    end
    tick();
  endtask

  task automatic test_read_before_write();
    logic [31:0] old_w;
    bus.rsp_ready = 1'b1;
`ifdef PROG_MEM_LOADER_EN
    ld_en = 1'b1; ld_addr = BASE + 32'h20; ld_data = 32'h5; exp_mem[8] = 32'h5;
    tick();
`endif
    old_w = exp_mem[8];
    ld_en = 1'b1; ld_addr = BASE + 32'h20; ld_data = 32'h1;
    bus.req_valid = 1'b1; bus.req_addr = BASE + 32'h20;
    tick();
`ifdef PROG_MEM_LOADER_EN
    exp_mem[8] = 32'h1;
`endif
    ld_en = 1'b0;
    checks++;
    if (rsp_vec !== {1'b1, 2'b00, BASE + 32'h20, old_w}) begin
      errors++; $display("FAIL rbw_old got %h want %h", rsp_vec, {1'b1, 2'b00, BASE + 32'h20, old_w});
    end
    tick();
    checks++;
    if (rsp_vec !== {1'b1, 2'b00, BASE + 32'h20, exp_mem[8]}) begin
      errors++; $display("FAIL rbw_new got %h want %h", rsp_vec, {1'b1, 2'b00, BASE + 32'h20, exp_mem[8]});
    end
    bus.req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = BASE + 32'h80; ld_data = 32'hdead_beef;
    tick();
    ld_addr = BASE + 32'h26; ld_data = 32'h77;
`ifdef PROG_MEM_LOADER_EN
    exp_mem[9] = 32'h77;
`endif
    tick();
    ld_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = BASE;
    tick();
    checks++;
    if (rsp_vec !== {1'b1, 2'b00, BASE, exp_mem[0]}) begin
      errors++; $display("FAIL ld_oor_drop got %h want %h", rsp_vec, {1'b1, 2'b00, BASE, exp_mem[0]});
    end
    bus.req_addr = BASE + 32'h24;
    tick();
    checks++;
    if (rsp_vec !== {1'b1, 2'b00, BASE + 32'h24, exp_mem[9]}) begin
      errors++; $display("FAIL ld_lowbits got %h want %h", rsp_vec, {1'b1, 2'b00, BASE + 32'h24, exp_mem[9]});
    end
    bus.req_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic        exp_ready;
    logic [31:0] a;
    int          sel;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      else if (sel == 8) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
      else               a = 32'($urandom_range(0, int'(BASE) - 1));
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.req_addr  = a;
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 19) == 0);
      ld_en         = ($urandom_range(0, 4) == 0);
      ld_addr       = BASE + 32'($urandom_range(0, 4 * DEPTH + 15));
      ld_data       = $urandom;
      #1;
      exp_ready = (exp_q.size() == 0) || bus.rsp_ready || flush;
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b want %b", c, bus.req_ready, exp_ready);
      end
      if (flush) exp_q.delete();
      else begin
        if (exp_q.size() != 0 && bus.rsp_ready) void'(exp_q.pop_front());
        if (bus.req_valid && exp_ready) exp_q.push_back(model_fetch(a));
      end
`ifdef PROG_MEM_LOADER_EN
      if (ld_en && addr_ok(ld_addr)) exp_mem[(ld_addr - BASE) / 4] = ld_data;
`endif
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        if (bus.rsp_valid !== 1'b0) begin
          errors++; $display("FAIL rand_idle cycle %0d got valid %b want 0", c, bus.rsp_valid);
        end
      end else if (rsp_vec !== {1'b1, exp_q[0]}) begin
        errors++; $display("FAIL rand_rsp cycle %0d got %h want %h", c, rsp_vec, {1'b1, exp_q[0]});
      end
    end
    drive_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_transfer();
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = BASE + 32'h4;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_vec !== {1'b0, 2'b00, 32'h0, NOP}) begin
      errors++; $display("FAIL rst_async got %h want %h", rsp_vec, {1'b0, 2'b00, 32'h0, NOP});
    end
    @(negedge clk);
    rst = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rst_no_rsp cycle %0d got %b want 0", c, bus.rsp_valid);
      end
    end
    bus.req_valid = 1'b1; bus.req_addr = BASE + 32'h8;
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (rsp_vec !== {1'b1, 2'b00, BASE + 32'h8, exp_mem[2]}) begin
      errors++; $display("FAIL rst_mem_kept got %h want %h", rsp_vec, {1'b1, 2'b00, BASE + 32'h8, exp_mem[2]});
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload();
    test_load_fetch();
    test_back_to_back();
    test_backpressure();
    test_faults();
    test_flush();
    test_read_before_write();
    test_random();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
